l2_request_arbiter: RTL and testbench

- Shares the single L2 request port between the icache (requester 0) and the dcache (requester 1).
- Arbitrates round-robin between the two.
- Once a requester is granted, the grant is held for up to one full line of word transfers, so line fills are never interleaved.
- Sits between the L1 caches and the L2 model/controller, and is pure sequencing logic.

---
 rtl/xentry_pkg.sv | 21 ++
 rtl/l2_arbiter_fsm.sv | 67 ++++++
 rtl/l2_request_arbiter.sv | 77 +++++++
 tb/tb_l2_request_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xentry_pkg.sv
// Shared types for the L1-to-L2 request path.
// Memory operation, arbiter state and requester ids.
package xentry_pkg;

  typedef enum logic {
    MEM_LOAD,
    MEM_STORE
  } memory_operation_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT_IC,
    ARB_GRANT_DC
  } arb_state_e;

  typedef enum logic {
    REQ_IC,
    REQ_DC
  } arb_requester_e;

endpackage

// File: rtl/l2_arbiter_fsm.sv
// Grant sequencer: round-robin owner choice, line-length beat count.
// Ports: clk, reset (async low), ic/dc valid, l2 fulfilled -> grant, sel.
module l2_arbiter_fsm
  import xentry_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           ic_valid,
  input  logic           dc_valid,
  input  logic           l2_fulfilled,
  output logic           grant,
  output arb_requester_e sel
);

  localparam int BW = $clog2(WORDS_PER_LINE) + 1;

  arb_state_e     state;
  arb_requester_e last_grant;
  logic [BW-1:0]  beat_count;
  logic [BW-1:0]  beat_next;
  logic           owner_valid;

  assign owner_valid = (state == ARB_GRANT_IC) ? ic_valid : dc_valid;
  assign beat_next   = beat_count + BW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ARB_IDLE;
      last_grant <= REQ_DC;
      beat_count <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          // Tie goes to whoever did not own the port last.
          if (ic_valid && (!dc_valid || last_grant == REQ_DC)) begin
            state      <= ARB_GRANT_IC;
            last_grant <= REQ_IC;
            beat_count <= '0;
          end else if (dc_valid) begin
            state      <= ARB_GRANT_DC;
            last_grant <= REQ_DC;
            beat_count <= '0;
          end
        end
        ARB_GRANT_IC,
        ARB_GRANT_DC: begin
          // Owner done (or aborted with nothing outstanding).
          if (!owner_valid) begin
            state <= ARB_IDLE;
          end else if (l2_fulfilled) begin
            beat_count <= beat_next;
            if (beat_next == BW'(WORDS_PER_LINE)) begin
              state <= ARB_IDLE;
            end
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign grant = (state == ARB_GRANT_IC) || (state == ARB_GRANT_DC);
  assign sel   = (state == ARB_GRANT_DC) ? REQ_DC : REQ_IC;

endmodule

// File: rtl/l2_request_arbiter.sv
// Shares the L2 request port between icache and dcache.
// Ports: ic_*/dc_* requester sides, l2_* forwarded port, clk, reset.
module l2_request_arbiter
  import xentry_pkg::*;
#(
  parameter int LINE_SIZE = 32,
  parameter int XLEN      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   ic_req_address,
  input  memory_operation_e ic_req_type,
  input  logic              ic_req_valid,
  output logic [XLEN-1:0]   ic_fetched_word,
  output logic              ic_req_fulfilled,
  input  logic [XLEN-1:0]   dc_req_address,
  input  memory_operation_e dc_req_type,
  input  logic              dc_req_valid,
  input  logic [XLEN-1:0]   dc_write_word,
  output logic [XLEN-1:0]   dc_fetched_word,
  output logic              dc_req_fulfilled,
  output logic [XLEN-1:0]   l2_req_address,
  output memory_operation_e l2_req_type,
  output logic              l2_req_valid,
  output logic [XLEN-1:0]   l2_write_word,
  input  logic [XLEN-1:0]   l2_fetched_word,
  input  logic              l2_req_fulfilled
);

  localparam int WORDS_PER_LINE = LINE_SIZE / (XLEN / 8);

  logic           grant;
  arb_requester_e sel;

  l2_arbiter_fsm #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_fsm (
    .clk         (clk),
    .reset       (reset),
    .ic_valid    (ic_req_valid),
    .dc_valid    (dc_req_valid),
    .l2_fulfilled(l2_req_fulfilled),
    .grant       (grant),
    .sel         (sel)
  );

  always_comb begin
    l2_req_valid     = 1'b0;
    l2_req_address   = '0;
    l2_req_type      = MEM_LOAD;
    l2_write_word    = '0;
    ic_fetched_word  = '0;
    ic_req_fulfilled = 1'b0;
    dc_fetched_word  = '0;
    dc_req_fulfilled = 1'b0;
    if (grant) begin
      unique case (sel)
        REQ_IC: begin
          l2_req_valid     = ic_req_valid;
          l2_req_address   = ic_req_address;
          l2_req_type      = ic_req_type;
          ic_fetched_word  = l2_fetched_word;
          ic_req_fulfilled = l2_req_fulfilled;
        end
        REQ_DC: begin
          l2_req_valid     = dc_req_valid;
          l2_req_address   = dc_req_address;
          l2_req_type      = dc_req_type;
          l2_write_word    = dc_write_word;
          dc_fetched_word  = l2_fetched_word;
          dc_req_fulfilled = l2_req_fulfilled;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// Directed bench for l2_request_arbiter.
// Drives both requesters and an L2 stub, checks with assertions.
module tb_l2_request_arbiter;
  import xentry_pkg::*;

  logic              clk;
  logic              reset;
  logic [31:0]       ic_req_address;
  memory_operation_e ic_req_type;
  logic              ic_req_valid;
  logic [31:0]       ic_fetched_word;
  logic              ic_req_fulfilled;
  logic [31:0]       dc_req_address;
  memory_operation_e dc_req_type;
  logic              dc_req_valid;
  logic [31:0]       dc_write_word;
  logic [31:0]       dc_fetched_word;
  logic              dc_req_fulfilled;
  logic [31:0]       l2_req_address;
  memory_operation_e l2_req_type;
  logic              l2_req_valid;
  logic [31:0]       l2_write_word;
  logic [31:0]       l2_fetched_word;
  logic              l2_req_fulfilled;

  int tests;
  int failed;

  l2_request_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .ic_req_address  (ic_req_address),
    .ic_req_type     (ic_req_type),
    .ic_req_valid    (ic_req_valid),
    .ic_fetched_word (ic_fetched_word),
    .ic_req_fulfilled(ic_req_fulfilled),
    .dc_req_address  (dc_req_address),
    .dc_req_type     (dc_req_type),
    .dc_req_valid    (dc_req_valid),
    .dc_write_word   (dc_write_word),
    .dc_fetched_word (dc_fetched_word),
    .dc_req_fulfilled(dc_req_fulfilled),
    .l2_req_address  (l2_req_address),
    .l2_req_type     (l2_req_type),
    .l2_req_valid    (l2_req_valid),
    .l2_write_word   (l2_write_word),
    .l2_fetched_word (l2_fetched_word),
    .l2_req_fulfilled(l2_req_fulfilled)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ic_req_address   = '0;
    ic_req_type      = MEM_LOAD;
    ic_req_valid     = 1'b0;
    dc_req_address   = '0;
    dc_req_type      = MEM_LOAD;
    dc_req_valid     = 1'b0;
    dc_write_word    = '0;
    l2_fetched_word  = '0;
    l2_req_fulfilled = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    idle_inputs();
    reset = 1'b0;
    #1;
    chk("rst_l2_valid", 32'(l2_req_valid), 32'd0);
    chk("rst_l2_addr", l2_req_address, 32'd0);
    chk("rst_l2_type", 32'(l2_req_type), 32'(MEM_LOAD));
    chk("rst_l2_wdata", l2_write_word, 32'd0);
    chk("rst_ic_ful", 32'(ic_req_fulfilled), 32'd0);
    chk("rst_dc_ful", 32'(dc_req_fulfilled), 32'd0);
    tick();
    tick();
    reset = 1'b1;

    // Single icache load
    ic_req_valid   = 1'b1;
    ic_req_address = 32'h100;
    #1;
    chk("ic_load_lat0", 32'(l2_req_valid), 32'd0);
    tick();
    chk("ic_load_valid", 32'(l2_req_valid), 32'd1);
    chk("ic_load_addr", l2_req_address, 32'h100);
    l2_fetched_word  = 32'hDEADBEEF;
    l2_req_fulfilled = 1'b1;
    #1;
    chk("ic_load_word", ic_fetched_word, 32'hDEADBEEF);
    chk("ic_load_ful", 32'(ic_req_fulfilled), 32'd1);
    chk("ic_load_dc_ful", 32'(dc_req_fulfilled), 32'd0);
    chk("ic_load_dc_word", dc_fetched_word, 32'd0);
    tick();
    ic_req_valid     = 1'b0;
    l2_req_fulfilled = 1'b0;
    #1;
    chk("ic_load_ful_end", 32'(ic_req_fulfilled), 32'd0);
    tick();
    chk("ic_load_idle", 32'(l2_req_valid), 32'd0);

    // Tie out of reset: icache first, then dcache after one idle cycle
    do_reset();
    ic_req_valid   = 1'b1;
    ic_req_address = 32'h300;
    dc_req_valid   = 1'b1;
    dc_req_address = 32'h400;
    tick();
    chk("tie_ic_first", l2_req_address, 32'h300);
    l2_req_fulfilled = 1'b1;
    tick();
    ic_req_valid     = 1'b0;
    l2_req_fulfilled = 1'b0;
    tick();
    chk("tie_gap_idle", 32'(l2_req_valid), 32'd0);
    tick();
    chk("tie_dc_valid", 32'(l2_req_valid), 32'd1);
    chk("tie_dc_addr", l2_req_address, 32'h400);
    l2_req_fulfilled = 1'b1;
    tick();
    dc_req_valid     = 1'b0;
    l2_req_fulfilled = 1'b0;
    tick();

    // Icache 8-beat fill with a waiting dcache store
    ic_req_valid   = 1'b1;
    ic_req_address = 32'h200;
    dc_req_valid   = 1'b1;
    dc_req_address = 32'h500;
    dc_req_type    = MEM_STORE;
    dc_write_word  = 32'h12345678;
    tick();
    chk("fill_ic_wdata0", l2_write_word, 32'd0);
    for (int i = 0; i < 8; i++) begin
      ic_req_address   = 32'h200 + 32'(4 * i);
      l2_fetched_word  = 32'hA0 + 32'(i);
      l2_req_fulfilled = 1'b1;
      #1;
      chk("fill_addr", l2_req_address, 32'h200 + 32'(4 * i));
      chk("fill_ic_ful", 32'(ic_req_fulfilled), 32'd1);
      chk("fill_ic_word", ic_fetched_word, 32'hA0 + 32'(i));
      chk("fill_dc_ful", 32'(dc_req_fulfilled), 32'd0);
      tick();
    end
    l2_req_fulfilled = 1'b0;
    #1;
    chk("fill_no_9th", 32'(l2_req_valid), 32'd0);
    tick();
    chk("st_addr", l2_req_address, 32'h500);
    chk("st_type", 32'(l2_req_type), 32'(MEM_STORE));
    chk("st_wdata", l2_write_word, 32'h12345678);
    l2_req_fulfilled = 1'b1;
    #1;
    chk("st_dc_ful", 32'(dc_req_fulfilled), 32'd1);
    chk("st_ic_ful", 32'(ic_req_fulfilled), 32'd0);
    tick();
    dc_req_valid     = 1'b0;
    dc_req_type      = MEM_LOAD;
    l2_req_fulfilled = 1'b0;
    tick();
    chk("st_rel_idle", 32'(l2_req_valid), 32'd0);
    tick();
    chk("ic_again_addr", l2_req_address, 32'h21C);
    chk("ic_again_type", 32'(l2_req_type), 32'(MEM_LOAD));
    l2_req_fulfilled = 1'b1;
    tick();
    ic_req_valid     = 1'b0;
    l2_req_fulfilled = 1'b0;
    tick();

    // Alternation over four ties, icache owned last
    ic_req_address = 32'h600;
    dc_req_address = 32'h700;
    for (int k = 0; k < 4; k++) begin
      ic_req_valid = 1'b1;
      dc_req_valid = 1'b1;
      tick();
      chk("alt_owner", l2_req_address,
          (k % 2 == 0) ? 32'h700 : 32'h600);
      l2_req_fulfilled = 1'b1;
      tick();
      ic_req_valid     = 1'b0;
      dc_req_valid     = 1'b0;
      l2_req_fulfilled = 1'b0;
      tick();
    end

    // Reset mid-beat while the dcache owns the port
    dc_req_valid   = 1'b1;
    dc_req_address = 32'h800;
    tick();
    chk("rmid_pre_valid", 32'(l2_req_valid), 32'd1);
    l2_fetched_word  = 32'hCAFEF00D;
    l2_req_fulfilled = 1'b1;
    reset            = 1'b0;
    #1;
    chk("rmid_valid", 32'(l2_req_valid), 32'd0);
    chk("rmid_addr", l2_req_address, 32'd0);
    chk("rmid_dc_ful", 32'(dc_req_fulfilled), 32'd0);
    chk("rmid_dc_word", dc_fetched_word, 32'd0);
    tick();
    l2_req_fulfilled = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("rmid_regrant", l2_req_address, 32'h800);
    chk("rmid_regrant_v", 32'(l2_req_valid), 32'd1);
    l2_req_fulfilled = 1'b1;
    tick();
    dc_req_valid     = 1'b0;
    l2_req_fulfilled = 1'b0;
    tick();

    // Owner drops valid with no beat outstanding
    ic_req_valid   = 1'b1;
    ic_req_address = 32'h900;
    tick();
    chk("abort_granted", 32'(l2_req_valid), 32'd1);
    ic_req_valid = 1'b0;
    #1;
    chk("abort_ic_ful", 32'(ic_req_fulfilled), 32'd0);
    chk("abort_dc_ful", 32'(dc_req_fulfilled), 32'd0);
    tick();
    ic_req_valid     = 1'b1;
    l2_req_fulfilled = 1'b1;
    #1;
    chk("abort_idle", 32'(l2_req_valid), 32'd0);
    chk("idle_ful_ign", 32'(ic_req_fulfilled), 32'd0);
    tick();
    l2_req_fulfilled = 1'b0;
    #1;
    chk("abort_regrant", 32'(l2_req_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
